pot_controller: RTL
===================

# pot_controller

Sequences the stove pot: accepts onions from the penguin, runs a frame-counted cook timer, holds finished soup until a plate collects it, and burns unattended soup. It sits between the penguin/interaction logic and the plate logic. It owns `potState`, and `plate` consumes that signal when filling a plate at the stove (`tileType == 3`).

## Interface
Parameters:
- `COOK_FRAMES`, default 320. Frames from the last onion to soup ready. Must be a multiple of 16 and ≥ 16.
- `BURN_FRAMES`, default 300. Frames soup may sit in READY before burning. Must be ≥ 2.
- `ONIONS_NEEDED`, default 3. Onions required to start cooking, range 1–3.
- `DEBOUNCE`, default 3. Minimum idle frames between accepted E presses.

Ports:
- `frame_clk` in 1. The vsync clock; all state updates on its rising edge.
- `Reset` in 1. Asynchronous, active-high.
- `keycode` in 8. Keyboard code; `8'h08` is E (interact).
- `wallFlag` in 1. Penguin is touching a counter or wall.
- `tileType` in 4. Tile the penguin faces; 3 = stove.
- `spriteIndexIn` in 3. Item held by the penguin: 0 = none, 1 = onion, 2 = plate.
- `plateState` in 2. Held plate contents; 0 = empty.
- `potState` out 2. 0 = empty or filling, 1 = onion soup ready, 2 = burnt, 3 never driven.
- `onionCount` out 2. Onions currently in the pot.
- `cookProgress` out 4. Progress-bar level, 0–15.
- `consumeIngredient` out 1. One-frame pulse telling the ingredient logic to drop the held onion.
- `servePulse` out 1. One-frame pulse when soup is transferred to a plate.

## Operation
- Debounce:
  - A 4-bit `dbnc` counter increments, saturating at 15, on every frame where `keycode != 8'h08`.
  - On a frame with `keycode == 8'h08` and `dbnc >= DEBOUNCE`, `evt` = 1 and `dbnc` clears.
  - On a frame with `keycode == 8'h08` and `dbnc < DEBOUNCE`, `dbnc` holds and there is no event. A held key therefore yields exactly one event.
- A stove interaction `act` = `evt && wallFlag && tileType == 3`. Events away from the stove are discarded but still clear `dbnc`.
- State machine, with states EMPTY, FILLING, COOKING, READY, BURNT:
  - **EMPTY:** on `act` with `spriteIndexIn == 1`:
    - `onionCount` becomes 1 and `consumeIngredient` pulses.
    - Next state is FILLING, or COOKING directly if `ONIONS_NEEDED == 1`.
  - **FILLING:** on `act` with onion held:
    - `onionCount` increments and `consumeIngredient` pulses.
    - When the new count equals `ONIONS_NEEDED`, go to COOKING and clear the timers.
  - **COOKING:** a 10-bit `timer` increments every frame. A step sub-counter wraps every `COOK_FRAMES/16` frames and increments `cookProgress`, saturating at 15.
    - When `timer == COOK_FRAMES-1`, go to READY, set `timer` to 0 and set `cookProgress` to 15.
    - All `act` events are ignored: no consume and no state change.
  - **READY:** `potState` = 1 and `timer` increments every frame.
    - On `act` with `spriteIndexIn == 2` and `plateState == 0`: `servePulse` pulses, then go to EMPTY and clear `onionCount`, `cookProgress` and `timer`.
    - Otherwise, when `timer == BURN_FRAMES-1`, go to BURNT.
  - **BURNT:** `potState` = 2.
    - On `act` with `spriteIndexIn == 0`, the pot is dumped: go to EMPTY and clear all counters.
    - Onions and plates are refused.
- `act` while holding a wrong item for the current state is a no-op in every state.
- At most one `consumeIngredient` or `servePulse` is asserted per frame, and never both.

## Timing
- All outputs are registered. After `Reset` they are all 0: `potState` = 0, `onionCount` = 0, `cookProgress` = 0, `consumeIngredient` = 0, `servePulse` = 0. The state is EMPTY and `dbnc` = 0.
- The first E press after reset is therefore accepted only after `DEBOUNCE` idle frames.
- Event latency: an `act` sampled at edge *n* updates the state and counters and raises its pulse at edge *n*. The pulse is visible for exactly one frame and drops at edge *n+1*.
- With the final onion accepted at edge *n*:
  - the pot is in COOKING from edge *n*;
  - `potState` becomes 1 at edge *n + COOK_FRAMES*;
  - `potState` becomes 2 at edge *n + COOK_FRAMES + BURN_FRAMES*, unless the soup is served first.
- Simultaneous events:
  - Serve and burn in the same frame: serve wins and the pot goes to EMPTY.
  - `act` on the frame COOKING expires: the event is ignored and the pot enters READY.
- `Reset` asserted mid-cook aborts immediately and asynchronously to the reset values. No pulses are emitted.
- Counter widths:
  - `timer` is 10 bits and never wraps, because it is cleared on each state change.
  - `COOK_FRAMES` and `BURN_FRAMES` must each be ≤ 1023.

## Test plan
- **Reset and debounce:** assert Reset, release, then hold `keycode = 8'h08` at the stove with an onion for 10 frames.
  - No consume during the first 3 frames (`dbnc` < 3).
  - After release, wait 3 frames and press again: `consumeIngredient` pulses once and `onionCount` = 1.
- **Fill and cook:** three spaced onion presses at the stove.
  - `consumeIngredient` pulses 3 times, `onionCount` = 3 and the state is COOKING.
  - `cookProgress` increments every 20 frames.
  - `potState` = 1 exactly 320 frames after the third press, with `cookProgress` = 15.
- **Serve:** in READY, press E with `spriteIndexIn = 2`, `plateState = 0`.
  - `servePulse` is high for one frame.
  - `potState`, `onionCount` and `cookProgress` are all 0 on the same edge.
- **Burn and dump:** leave READY for 300 frames.
  - `potState` = 2.
  - Pressing E with an onion gives no consume. Pressing with a plate gives no serve.
  - Pressing empty-handed returns `potState` to 0.
- **Illegal actions:**
  - An onion press during COOKING is ignored.
  - A press with `tileType = 1` or `wallFlag = 0` is ignored but requires 3 idle frames before the next press.
  - A plate with `plateState = 1` in READY gives no serve.
- **Races:**
  - A serve press on the frame `timer == 299` in READY serves and does not burn.
  - `Reset` pulsed mid-COOKING clears all outputs asynchronously, with no pulse glitch.

Source files
------------

// File: rtl/pot_controller_if.sv
// Signal bundle between the penguin/interaction side and the stove pot controller.
// The master drives the penguin-side inputs; the slave (the pot) drives the pot status and pulses.
interface pot_controller_if;
  logic [7:0] keycode;
  logic       wallFlag;
  logic [3:0] tileType;
  logic [2:0] spriteIndexIn;
  logic [1:0] plateState;
  logic [1:0] potState;
  logic [1:0] onionCount;
  logic [3:0] cookProgress;
  logic       consumeIngredient;
  logic       servePulse;

  modport master (
    output keycode, wallFlag, tileType, spriteIndexIn, plateState,
    input  potState, onionCount, cookProgress, consumeIngredient, servePulse
  );

  modport slave (
    input  keycode, wallFlag, tileType, spriteIndexIn, plateState,
    output potState, onionCount, cookProgress, consumeIngredient, servePulse
  );
endinterface

// File: rtl/pot_controller.sv
// Stove pot sequencer: takes onions, cooks on a frame timer, holds soup for a plate,
// and burns soup left too long. All outputs are registered on frame_clk.
module pot_controller #(
  parameter int COOK_FRAMES   = 320,
  parameter int BURN_FRAMES   = 300,
  parameter int ONIONS_NEEDED = 3,
  parameter int DEBOUNCE      = 3
) (
  input logic              frame_clk,
  input logic              Reset,
  pot_controller_if.slave  bus
);

  localparam logic [9:0] COOK_LAST = 10'(COOK_FRAMES - 1);
  localparam logic [9:0] BURN_LAST = 10'(BURN_FRAMES - 1);
  localparam logic [9:0] STEP_LAST = 10'(COOK_FRAMES / 16 - 1);
  localparam logic [1:0] ONIONS_N  = 2'(ONIONS_NEEDED);
  localparam logic [3:0] DBNC_MIN  = 4'(DEBOUNCE);

  typedef enum logic [2:0] {EMPTY, FILLING, COOKING, READY, BURNT} state_t;

  state_t     state_reg, state_next;
  logic [3:0] dbnc_reg, dbnc_next;
  logic [9:0] timer_reg, timer_next;
  logic [9:0] step_reg, step_next;
  logic [1:0] onion_reg, onion_next;
  logic [3:0] progress_reg, progress_next;
  logic [1:0] pot_reg, pot_next;
  logic       consume_reg, consume_next;
  logic       serve_reg, serve_next;

  logic       press, evt, act;
  logic       onion_held, plate_ok, empty_hand;
  logic [1:0] onion_inc;

  // A held key produces one event: dbnc only recovers on frames without E.
  assign press = (bus.keycode == 8'h08);
  assign evt   = press && (dbnc_reg >= DBNC_MIN);
  assign act   = evt && bus.wallFlag && (bus.tileType == 4'd3);

  assign onion_held = (bus.spriteIndexIn == 3'd1);
  assign plate_ok   = (bus.spriteIndexIn == 3'd2) && (bus.plateState == 2'd0);
  assign empty_hand = (bus.spriteIndexIn == 3'd0);
  assign onion_inc  = onion_reg + 2'd1;

  always_comb begin
    dbnc_next = dbnc_reg;
    if (!press) begin
      if (dbnc_reg != 4'd15) dbnc_next = dbnc_reg + 4'd1;
    end else if (evt) begin
      dbnc_next = 4'd0;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state_reg <= EMPTY;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    onion_next    = onion_reg;
    timer_next    = timer_reg;
    step_next     = step_reg;
    progress_next = progress_reg;
    unique case (state_reg)
      EMPTY: begin
        if (act && onion_held) begin
          onion_next    = 2'd1;
          timer_next    = 10'd0;
          step_next     = 10'd0;
          progress_next = 4'd0;
          state_next    = (ONIONS_NEEDED == 1) ? COOKING : FILLING;
        end
      end
      FILLING: begin
        if (act && onion_held) begin
          onion_next = onion_inc;
          if (onion_inc == ONIONS_N) begin
            state_next    = COOKING;
            timer_next    = 10'd0;
            step_next     = 10'd0;
            progress_next = 4'd0;
          end
        end
      end
      COOKING: begin
        if (timer_reg == COOK_LAST) begin
          state_next    = READY;
          timer_next    = 10'd0;
          step_next     = 10'd0;
          progress_next = 4'd15;
        end else begin
          timer_next = timer_reg + 10'd1;
          if (step_reg == STEP_LAST) begin
            step_next = 10'd0;
            if (progress_reg != 4'd15) progress_next = progress_reg + 4'd1;
          end else begin
            step_next = step_reg + 10'd1;
          end
        end
      end
      READY: begin
        // Serving takes priority over burning on the same frame.
        if (act && plate_ok) begin
          state_next    = EMPTY;
          onion_next    = 2'd0;
          progress_next = 4'd0;
          timer_next    = 10'd0;
          step_next     = 10'd0;
        end else if (timer_reg == BURN_LAST) begin
          state_next = BURNT;
          timer_next = 10'd0;
        end else begin
          timer_next = timer_reg + 10'd1;
        end
      end
      BURNT: begin
        if (act && empty_hand) begin
          state_next    = EMPTY;
          onion_next    = 2'd0;
          progress_next = 4'd0;
          timer_next    = 10'd0;
          step_next     = 10'd0;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    pot_next     = 2'd0;
    consume_next = 1'b0;
    serve_next   = 1'b0;
    if (state_next == READY) pot_next = 2'd1;
    if (state_next == BURNT) pot_next = 2'd2;
    if (act && onion_held && (state_reg == EMPTY || state_reg == FILLING)) consume_next = 1'b1;
    if (act && plate_ok && state_reg == READY) serve_next = 1'b1;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      dbnc_reg     <= 4'd0;
      timer_reg    <= 10'd0;
      step_reg     <= 10'd0;
      onion_reg    <= 2'd0;
      progress_reg <= 4'd0;
      pot_reg      <= 2'd0;
      consume_reg  <= 1'b0;
      serve_reg    <= 1'b0;
    end else begin
      dbnc_reg     <= dbnc_next;
      timer_reg    <= timer_next;
      step_reg     <= step_next;
      onion_reg    <= onion_next;
      progress_reg <= progress_next;
      pot_reg      <= pot_next;
      consume_reg  <= consume_next;
      serve_reg    <= serve_next;
    end
  end

  assign bus.potState          = pot_reg;
  assign bus.onionCount        = onion_reg;
  assign bus.cookProgress      = progress_reg;
  assign bus.consumeIngredient = consume_reg;
  assign bus.servePulse        = serve_reg;

endmodule
